signed_digit_decompose_pipe: RTL and testbench

SIGNED_DIGIT_DECOMPOSE_PIPE -- requirements
Module: signed_digit_decompose_pipe

---
 rtl/signed_digit_decompose_pipe_if.sv | 36 +++
 rtl/signed_digit_decompose_pipe.sv | 127 ++++++++++++
 tb/tb_signed_digit_decompose_pipe.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/signed_digit_decompose_pipe_if.sv
// Handshake bundle for signed_digit_decompose_pipe. The optional tag lanes
// exist only when SDD_TAG_EN is defined.
interface signed_digit_decompose_pipe_if #(
  parameter int DATA_W     = 28,
  parameter int NUM_DIGITS = 4,
  parameter int TAG_W      = 8
);
  logic                         in_valid;
  logic                         in_ready;
  logic [DATA_W-1:0]            value_in;
  logic                         out_valid;
  logic                         out_ready;
  logic [NUM_DIGITS*DATA_W-1:0] digits_out;
`ifdef SDD_TAG_EN
  logic [TAG_W-1:0]             tag_in;
  logic [TAG_W-1:0]             tag_out;
`endif

  modport master (
    output in_valid, value_in, out_ready,
`ifdef SDD_TAG_EN
    output tag_in,
    input  tag_out,
`endif
    input  in_ready, out_valid, digits_out
  );

  modport slave (
    input  in_valid, value_in, out_ready,
`ifdef SDD_TAG_EN
    input  tag_in,
    output tag_out,
`endif
    output in_ready, out_valid, digits_out
  );
endinterface

// File: rtl/signed_digit_decompose_pipe.sv
// Centred signed-digit decomposition of a residue mod Q into NUM_DIGITS base-2^BASE_LOG
// digits, one digit per pipeline stage. Optional macro SDD_TAG_EN carries a tag with each word.
module signed_digit_decompose_pipe #(
  parameter int DATA_W     = 28,
  parameter int MODULUS    = 12289,
  parameter int BASE_LOG   = 7,
  parameter int NUM_DIGITS = 4
`ifdef SDD_TAG_EN
  ,
  parameter int TAG_W      = 8
`endif
) (
  input logic                          clk,
  input logic                          rst_n,
  signed_digit_decompose_pipe_if.slave bus
);
  localparam int R     = BASE_LOG * NUM_DIGITS;
  localparam int DIG_W = NUM_DIGITS * DATA_W;

  if (R < DATA_W || BASE_LOG < 2 || (MODULUS % 2) == 0 ||
      longint'(MODULUS) >= (64'sd1 <<< (DATA_W - 1))) begin : g_bad_params
    $fatal(1, "signed_digit_decompose_pipe: illegal parameter set");
  end

  function automatic logic signed [R-1:0] f_centre(input logic [DATA_W-1:0] v);
    logic [R-1:0] vx;
    vx = R'(v);
    if (v <= DATA_W'((MODULUS - 1) / 2)) return signed'(vx);
    return signed'(vx - R'(MODULUS));
  endfunction

  // Negative digits are mapped back into [0, Q) by adding Q.
  function automatic logic [DATA_W-1:0] f_digit(input logic [BASE_LOG-1:0] low);
    if (!low[BASE_LOG-1]) return DATA_W'(low);
    return DATA_W'(low) + DATA_W'(MODULUS) - DATA_W'(2 ** BASE_LOG);
  endfunction

  logic [NUM_DIGITS:0]    r_vld;
  logic [NUM_DIGITS:0]    w_adv;
  logic signed [R-1:0]    r_res_p   [NUM_DIGITS];
  logic [DIG_W-1:0]       r_dig_p   [NUM_DIGITS];
  logic [DIG_W-1:0]       r_dig_out;
  logic signed [R-1:0]    w_res_nxt [NUM_DIGITS];
  logic [DIG_W-1:0]       w_dig_nxt [NUM_DIGITS+1];
`ifdef SDD_TAG_EN
  logic [TAG_W-1:0]       r_tag_p   [NUM_DIGITS];
  logic [TAG_W-1:0]       r_tag_out;
`endif

  // A stage advances when it or any stage downstream of it has a hole, or the sink takes.
  always_comb begin
    w_adv = '0;
    for (int k = 0; k <= NUM_DIGITS; k++) begin
      w_adv[k] = bus.out_ready |
                 ~(&(r_vld | (NUM_DIGITS+1)'((1 << k) - 1)));
    end
  end

  always_comb begin : p_digit
    logic [BASE_LOG-1:0] low;
    logic signed [R-1:0] shifted;
    low     = '0;
    shifted = '0;
    for (int k = 0; k < NUM_DIGITS; k++) w_res_nxt[k] = '0;
    for (int k = 0; k <= NUM_DIGITS; k++) w_dig_nxt[k] = '0;
    for (int k = 1; k <= NUM_DIGITS; k++) begin
      low          = r_res_p[k-1][BASE_LOG-1:0];
      w_dig_nxt[k] = r_dig_p[k-1];
      w_dig_nxt[k][(k-1)*DATA_W +: DATA_W] = f_digit(low);
    end
    for (int k = 1; k < NUM_DIGITS; k++) begin
      low          = r_res_p[k-1][BASE_LOG-1:0];
      shifted      = r_res_p[k-1] >>> BASE_LOG;
      w_res_nxt[k] = shifted + R'(low[BASE_LOG-1]);
    end
  end

  // Stage 0 captures the centred input; stages 1..NUM_DIGITS-1 peel one digit each.
  always_ff @(posedge clk) begin
    if (w_adv[0] && bus.in_valid) begin
      r_res_p[0] <= f_centre(bus.value_in);
      r_dig_p[0] <= '0;
`ifdef SDD_TAG_EN
      r_tag_p[0] <= bus.tag_in;
`endif
    end
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (w_adv[k] && r_vld[k-1]) begin
        r_res_p[k] <= w_res_nxt[k];
        r_dig_p[k] <= w_dig_nxt[k];
`ifdef SDD_TAG_EN
        r_tag_p[k] <= r_tag_p[k-1];
`endif
      end
    end
  end

  // Final stage: last digit joins the word; this register is the visible output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld     <= '0;
      r_dig_out <= '0;
`ifdef SDD_TAG_EN
      r_tag_out <= '0;
`endif
    end else begin
      if (w_adv[0]) r_vld[0] <= bus.in_valid;
      for (int k = 1; k <= NUM_DIGITS; k++) begin
        if (w_adv[k]) r_vld[k] <= r_vld[k-1];
      end
      if (w_adv[NUM_DIGITS] && r_vld[NUM_DIGITS-1]) begin
        r_dig_out <= w_dig_nxt[NUM_DIGITS];
`ifdef SDD_TAG_EN
        r_tag_out <= r_tag_p[NUM_DIGITS-1];
`endif
      end
    end
  end

  assign bus.in_ready   = rst_n & w_adv[0];
  assign bus.out_valid  = r_vld[NUM_DIGITS];
  assign bus.digits_out = r_dig_out;
`ifdef SDD_TAG_EN
  assign bus.tag_out    = r_tag_out;
`endif

endmodule

// File: tb/tb_signed_digit_decompose_pipe.sv
// Self-checking bench for signed_digit_decompose_pipe: directed digit vectors,
// a randomized stalled stream against an arithmetic reference, and mid-stream reset.
module tb_signed_digit_decompose_pipe;
  localparam int DATA_W = 28;
  localparam int Q      = 12289;
  localparam int BL     = 7;
  localparam int ND     = 4;
  localparam int B      = 1 << BL;
  localparam int DW     = ND * DATA_W;
  localparam int NWORDS = 20;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  signed_digit_decompose_pipe_if #(.DATA_W(DATA_W), .NUM_DIGITS(ND), .TAG_W(8)) bus ();

  signed_digit_decompose_pipe #(
    .DATA_W(DATA_W), .MODULUS(Q), .BASE_LOG(BL), .NUM_DIGITS(ND)
`ifdef SDD_TAG_EN
    , .TAG_W(8)
`endif
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pack(input int d0, input int d1, input int d2, input int d3);
    logic [DW-1:0] p;
    p = '0;
    p[0*DATA_W +: DATA_W] = DATA_W'(d0);
    p[1*DATA_W +: DATA_W] = DATA_W'(d1);
    p[2*DATA_W +: DATA_W] = DATA_W'(d2);
    p[3*DATA_W +: DATA_W] = DATA_W'(d3);
    return p;
  endfunction

  // Reference: centred integer, repeated floor-division by B with balanced remainder.
  function automatic logic [DW-1:0] model(input int unsigned v);
    longint d, low, dig;
    int     c;
    logic [DW-1:0] p;
    p = '0;
    d = (v <= (Q - 1) / 2) ? longint'(v) : longint'(v) - Q;
    for (int i = 0; i < ND; i++) begin
      low = d % B;
      if (low < 0) low = low + B;
      if (low < B / 2) begin
        dig = low;
        c   = 0;
      end else begin
        dig = low - B + Q;
        c   = 1;
      end
      p[i*DATA_W +: DATA_W] = DATA_W'(dig);
      d = (d - low) / B + c;
    end
    return p;
  endfunction

  task automatic send_one(input int unsigned v, input logic [DW-1:0] exp, input string tag);
    int lat;
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.value_in  = DATA_W'(v);
    bus.out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 5);
    check({tag, "_digits"}, bus.digits_out, exp);
  endtask

  logic [DW-1:0] exp_q [$];
  logic [7:0]    tag_q [$];
  int unsigned   vals  [NWORDS];
  logic [DW-1:0] prev_digits;
  logic          stalled_prev;
  logic          seen;
  int            sent, got, cyc;

  initial begin
    errors = 0;
    checks = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.value_in  = '0;
    bus.out_ready = 1'b0;
`ifdef SDD_TAG_EN
    bus.tag_in    = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_in_ready", bus.in_ready, 0);
    check("reset_digits", bus.digits_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_in_ready", bus.in_ready, 1);

    send_one(5,     pack(5, 0, 0, 0),     "v5");
    send_one(64,    pack(12225, 1, 0, 0), "v64");
    send_one(12288, pack(12288, 0, 0, 0), "v12288");
    send_one(6144,  pack(0, 48, 0, 0),    "v6144");
    send_one(6145,  pack(0, 12241, 0, 0), "v6145");

    // Randomized back-to-back stream with a pseudo-random stalling sink.
    for (int i = 0; i < NWORDS; i++) vals[i] = $urandom_range(0, Q - 1);
    vals[3] = (Q - 1) / 2;
    vals[7] = (Q + 1) / 2;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    sent = 0; got = 0; cyc = 0;
    stalled_prev = 1'b0;
    prev_digits  = '0;
    while (got < NWORDS && cyc < 600) begin
      @(posedge clk); #1;
      if (stalled_prev) begin
        check("stall_hold_valid", bus.out_valid, 1);
        check("stall_hold_digits", bus.digits_out, prev_digits);
      end
      bus.in_valid  = (sent < NWORDS);
      bus.value_in  = (sent < NWORDS) ? DATA_W'(vals[sent]) : '0;
`ifdef SDD_TAG_EN
      bus.tag_in    = 8'(sent);
`endif
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      check("stream_in_ready", bus.in_ready, (exp_q.size() < ND + 1) || bus.out_ready);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream_spurious_word", bus.out_valid, 0);
        end else begin
          check("stream_digits", bus.digits_out, exp_q.pop_front());
`ifdef SDD_TAG_EN
          check("stream_tag", bus.tag_out, tag_q.pop_front());
`endif
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(vals[sent]));
        tag_q.push_back(8'(sent));
        sent++;
      end
      stalled_prev = bus.out_valid && !bus.out_ready;
      prev_digits  = bus.digits_out;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("stream_sent", sent, NWORDS);
    check("stream_received", got, NWORDS);
    check("stream_queue_empty", exp_q.size(), 0);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("stream_no_duplicate", seen, 0);

    // Three words in flight, sink stalled, then an asynchronous reset pulse.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.value_in = DATA_W'(100 + i);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset_out_valid", bus.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_out_valid", bus.out_valid, 0);
    check("mid_reset_in_ready", bus.in_ready, 0);
    check("mid_reset_digits", bus.digits_out, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("no_stale_after_reset", seen, 0);
    send_one(vals[0], model(vals[0]), "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
